// File: rtl/vec_dispatch_scheduler.sv
// vec_dispatch_scheduler: issue scheduler for the vector coprocessor.
// Accepts decoded vector ops, stalls on RAW/WAW against a registered
// scoreboard of pending VRF writes, dispatches to the LSU or EXEC unit,
// arbitrates the single VRF write port between completions and reports
// each retired op on one result handshake.
// Optional build macro: VSCHED_INORDER_EN (retire strictly in accept order).

// Per-unit issue FSM plus the op fields latched at accept.
module vec_dispatch_unit #(
    parameter int VA         = 4,
    parameter int X_ID_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  accept_i,
    input  logic                  done_i,
    input  logic                  grant_i,
    input  logic [X_ID_WIDTH-1:0] id_i,
    input  logic [VA-1:0]         vd_i,
    input  logic                  we_i,
    output logic                  idle_o,
    output logic                  start_o,
    output logic                  done_st_o,
    output logic [X_ID_WIDTH-1:0] id_o,
    output logic [VA-1:0]         vd_o,
    output logic                  we_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN, ST_DONE} state_e;

    state_e state_q, state_d;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state; done_i only matters while the unit is running
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept_i) state_d = ST_START;
            ST_START: state_d = ST_RUN;
            ST_RUN:   if (done_i) state_d = ST_DONE;
            ST_DONE:  if (grant_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Capture the op's identity at accept; held until the next accept
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_o <= '0;
            vd_o <= '0;
            we_o <= 1'b0;
        end else if (accept_i) begin
            id_o <= id_i;
            vd_o <= vd_i;
            we_o <= we_i;
        end
    end

    assign idle_o    = (state_q == ST_IDLE);
    assign start_o   = (state_q == ST_START);
    assign done_st_o = (state_q == ST_DONE);

endmodule

module vec_dispatch_scheduler #(
    parameter int NUM_VREGS  = 16,
    parameter int X_ID_WIDTH = 4,
    localparam int VA        = $clog2(NUM_VREGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    input  logic                  op_unit_i,
    input  logic [VA-1:0]         op_src_a_i,
    input  logic [VA-1:0]         op_src_b_i,
    input  logic                  op_src_a_en_i,
    input  logic                  op_src_b_en_i,
    input  logic [VA-1:0]         op_vd_i,
    input  logic                  op_we_i,
    input  logic [X_ID_WIDTH-1:0] op_id_i,
    output logic                  lsu_start_o,
    output logic                  exec_start_o,
    input  logic                  lsu_done_i,
    input  logic                  exec_done_i,
    output logic                  vrf_we_o,
    output logic [VA-1:0]         vrf_waddr_o,
    output logic                  vrf_wsel_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [X_ID_WIDTH-1:0] result_id_o,
    output logic [NUM_VREGS-1:0]  sb_o,
    output logic                  busy_o
);

    localparam int NUM_UNITS = 2;  // index 0 = LSU, 1 = EXEC

    logic [NUM_UNITS-1:0]                 unit_idle, unit_start, unit_done_st;
    logic [NUM_UNITS-1:0]                 unit_acc, unit_elig, unit_gnt, unit_done_in;
    logic [NUM_UNITS-1:0][X_ID_WIDTH-1:0] unit_id;
    logic [NUM_UNITS-1:0][VA-1:0]         unit_vd;
    logic [NUM_UNITS-1:0]                 unit_we;

    logic [NUM_VREGS-1:0]  sb_q, sb_set, sb_clr;
    logic                  hazard, accept, res_free, gnt_any, gsel;
    logic                  result_valid_q;
    logic [X_ID_WIDTH-1:0] result_id_q;

    assign unit_done_in = {exec_done_i, lsu_done_i};

    // Two identical, independent execution-unit trackers
    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
        vec_dispatch_unit #(
            .VA         (VA),
            .X_ID_WIDTH (X_ID_WIDTH)
        ) u_unit (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .accept_i  (unit_acc[g]),
            .done_i    (unit_done_in[g]),
            .grant_i   (unit_gnt[g]),
            .id_i      (op_id_i),
            .vd_i      (op_vd_i),
            .we_i      (op_we_i),
            .idle_o    (unit_idle[g]),
            .start_o   (unit_start[g]),
            .done_st_o (unit_done_st[g]),
            .id_o      (unit_id[g]),
            .vd_o      (unit_vd[g]),
            .we_o      (unit_we[g])
        );
    end

    // RAW/WAW check against the registered scoreboard only (no bypass)
    always_comb begin
        hazard = 1'b0;
        if (op_src_a_en_i && sb_q[op_src_a_i]) hazard = 1'b1;
        if (op_src_b_en_i && sb_q[op_src_b_i]) hazard = 1'b1;
        if (op_we_i && sb_q[op_vd_i])          hazard = 1'b1;
    end

    assign op_ready_o  = unit_idle[op_unit_i] && !hazard;
    assign accept      = op_valid_i && op_ready_o;
    assign unit_acc[0] = accept && !op_unit_i;
    assign unit_acc[1] = accept && op_unit_i;

    // A unit may retire only if the result slot is empty or draining now
    assign res_free = !result_valid_q || result_ready_i;

`ifdef VSCHED_INORDER_EN
    logic age_q;  // index of the older busy unit

    // The younger unit waits in DONE while the older one is still busy
    always_comb begin
        unit_elig[0] = unit_done_st[0] && res_free && !(!unit_idle[1] && age_q != 1'b0);
        unit_elig[1] = unit_done_st[1] && res_free && !(!unit_idle[0] && age_q != 1'b1);
        unit_gnt     = unit_elig;
    end

    // The new op is younger only if the other unit stays busy past this edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            age_q <= 1'b0;
        end else if (unit_acc[0]) begin
            age_q <= (!unit_idle[1] && !unit_gnt[1]) ? 1'b1 : 1'b0;
        end else if (unit_acc[1]) begin
            age_q <= (!unit_idle[0] && !unit_gnt[0]) ? 1'b0 : 1'b1;
        end
    end
`else
    logic rr_ptr_q;  // unit favoured on the next tie

    // Completion order, round-robin only when both units contend
    always_comb begin
        unit_elig[0] = unit_done_st[0] && res_free;
        unit_elig[1] = unit_done_st[1] && res_free;
        unit_gnt[0]  = unit_elig[0] && (!unit_elig[1] || !rr_ptr_q);
        unit_gnt[1]  = unit_elig[1] && (!unit_elig[0] || rr_ptr_q);
    end

    // Pointer moves off the winner only after a contended grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                        rr_ptr_q <= 1'b0;
        else if (unit_elig[0] && unit_elig[1]) rr_ptr_q <= !rr_ptr_q;
    end
`endif

    assign gnt_any     = |unit_gnt;
    assign gsel        = unit_gnt[1];
    assign vrf_we_o    = gnt_any && unit_we[gsel];
    assign vrf_waddr_o = gnt_any ? unit_vd[gsel] : '0;
    assign vrf_wsel_o  = gsel;

    // Scoreboard set/clear masks; WAW stall keeps them disjoint
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (accept && op_we_i) sb_set[op_vd_i]     = 1'b1;
        if (vrf_we_o)          sb_clr[vrf_waddr_o] = 1'b1;
    end

    // Scoreboard register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sb_q <= '0;
        else         sb_q <= (sb_q & ~sb_clr) | sb_set;
    end

    // Result slot: loaded on retire, held until the consumer takes it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
        end else if (gnt_any) begin
            result_valid_q <= 1'b1;
            result_id_q    <= unit_id[gsel];
        end else if (result_ready_i) begin
            result_valid_q <= 1'b0;
        end
    end

    assign lsu_start_o    = unit_start[0];
    assign exec_start_o   = unit_start[1];
    assign result_valid_o = result_valid_q;
    assign result_id_o    = result_id_q;
    assign sb_o           = sb_q;
    assign busy_o         = !(&unit_idle) || result_valid_q;

endmodule

// File: tb/tb_vec_dispatch_scheduler.sv
// Directed self-checking bench for vec_dispatch_scheduler.
// Inputs change 1 ns after the rising edge; outputs are sampled 3 ns after.
module tb_vec_dispatch_scheduler;

    localparam int NV = 16;
    localparam int XW = 4;
    localparam int VA = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          op_valid_i, op_ready_o, op_unit_i;
    logic [VA-1:0] op_src_a_i, op_src_b_i, op_vd_i;
    logic          op_src_a_en_i, op_src_b_en_i, op_we_i;
    logic [XW-1:0] op_id_i;
    logic          lsu_start_o, exec_start_o, lsu_done_i, exec_done_i;
    logic          vrf_we_o, vrf_wsel_o;
    logic [VA-1:0] vrf_waddr_o;
    logic          result_valid_o, result_ready_i;
    logic [XW-1:0] result_id_o;
    logic [NV-1:0] sb_o;
    logic          busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    vec_dispatch_scheduler #(.NUM_VREGS(NV), .X_ID_WIDTH(XW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .op_valid_i     (op_valid_i),
        .op_ready_o     (op_ready_o),
        .op_unit_i      (op_unit_i),
        .op_src_a_i     (op_src_a_i),
        .op_src_b_i     (op_src_b_i),
        .op_src_a_en_i  (op_src_a_en_i),
        .op_src_b_en_i  (op_src_b_en_i),
        .op_vd_i        (op_vd_i),
        .op_we_i        (op_we_i),
        .op_id_i        (op_id_i),
        .lsu_start_o    (lsu_start_o),
        .exec_start_o   (exec_start_o),
        .lsu_done_i     (lsu_done_i),
        .exec_done_i    (exec_done_i),
        .vrf_we_o       (vrf_we_o),
        .vrf_waddr_o    (vrf_waddr_o),
        .vrf_wsel_o     (vrf_wsel_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_id_o    (result_id_o),
        .sb_o           (sb_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        #2;
    endtask

    task automatic op(input logic u, input logic [VA-1:0] vd, input logic we,
                      input logic [XW-1:0] id, input logic aen, input logic [VA-1:0] a);
        op_valid_i    = 1'b1;
        op_unit_i     = u;
        op_vd_i       = vd;
        op_we_i       = we;
        op_id_i       = id;
        op_src_a_en_i = aen;
        op_src_a_i    = a;
        op_src_b_en_i = 1'b0;
        op_src_b_i    = '0;
    endtask

    task automatic noop();
        op_valid_i = 1'b0;
        op_we_i    = 1'b0;
        op_src_a_en_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        op_valid_i = 0; op_unit_i = 0; op_src_a_i = 0; op_src_b_i = 0;
        op_src_a_en_i = 0; op_src_b_en_i = 0; op_vd_i = 0; op_we_i = 0; op_id_i = 0;
        lsu_done_i = 0; exec_done_i = 0; result_ready_i = 1;

        // Reset state
        repeat (2) @(posedge clk_i);
        #3;
        check("rst_lstart", lsu_start_o, 0);
        check("rst_estart", exec_start_o, 0);
        check("rst_vrf_we", vrf_we_o, 0);
        check("rst_waddr", vrf_waddr_o, 0);
        check("rst_wsel", vrf_wsel_o, 0);
        check("rst_rvalid", result_valid_o, 0);
        check("rst_rid", result_id_o, 0);
        check("rst_sb", sb_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", op_ready_o, 1);
        rst_ni = 1'b1;

        // Single EXEC op: vd 3, id 5
        cyc(); op(1, 3, 1, 5, 0, 0); smp();
        check("t1_ready", op_ready_o, 1);
        cyc(); noop(); smp();
        check("t1_estart", exec_start_o, 1);
        check("t1_lstart", lsu_start_o, 0);
        check("t1_sb", sb_o, 16'h0008);
        check("t1_busy", busy_o, 1);
        cyc(); exec_done_i = 1; smp();
        check("t1_estart_off", exec_start_o, 0);
        check("t1_we_early", vrf_we_o, 0);
        cyc(); exec_done_i = 0; smp();
        check("t1_vrf_we", vrf_we_o, 1);
        check("t1_waddr", vrf_waddr_o, 3);
        check("t1_wsel", vrf_wsel_o, 1);
        check("t1_rv_early", result_valid_o, 0);
        cyc(); smp();
        check("t1_rv", result_valid_o, 1);
        check("t1_rid", result_id_o, 5);
        check("t1_sb_clr", sb_o, 0);
        check("t1_we_off", vrf_we_o, 0);
        cyc(); smp();
        check("t1_rv_drop", result_valid_o, 0);
        check("t1_idle", busy_o, 0);

        // RAW: LSU load vd 2, then EXEC reading v2
        cyc(); op(0, 2, 1, 1, 0, 0); smp();
        check("t2_ld_ready", op_ready_o, 1);
        cyc(); op(1, 4, 1, 2, 1, 2); smp();
        check("t2_stall0", op_ready_o, 0);
        check("t2_lstart", lsu_start_o, 1);
        cyc(); lsu_done_i = 1; smp();
        check("t2_stall1", op_ready_o, 0);
        cyc(); lsu_done_i = 0; smp();
        check("t2_stall2", op_ready_o, 0);
        check("t2_vrf_we", vrf_we_o, 1);
        check("t2_waddr", vrf_waddr_o, 2);
        check("t2_wsel", vrf_wsel_o, 0);
        cyc(); smp();
        check("t2_ready", op_ready_o, 1);
        check("t2_rv", result_valid_o, 1);
        check("t2_rid", result_id_o, 1);
        check("t2_sb_clr", sb_o, 0);
        cyc(); noop(); smp();
        check("t2_estart", exec_start_o, 1);
        check("t2_sb4", sb_o, 16'h0010);
        cyc(); exec_done_i = 1; smp();
        cyc(); exec_done_i = 0; smp();
        check("t2_ewaddr", vrf_waddr_o, 4);
        check("t2_ewsel", vrf_wsel_o, 1);
        cyc(); smp();
        check("t2_rid2", result_id_o, 2);
        cyc(); smp();
        check("t2_idle", busy_o, 0);

        // First tie: LSU wins from reset pointer
        cyc(); op(0, 5, 1, 3, 0, 0); smp();
        cyc(); op(1, 6, 1, 4, 0, 0); smp();
        check("t3_e_ready", op_ready_o, 1);
        check("t3_lstart", lsu_start_o, 1);
        cyc(); noop(); smp();
        check("t3_estart", exec_start_o, 1);
        cyc(); lsu_done_i = 1; exec_done_i = 1; smp();
        cyc(); lsu_done_i = 0; exec_done_i = 0; smp();
        check("t3_w1_addr", vrf_waddr_o, 5);
        check("t3_w1_sel", vrf_wsel_o, 0);
        cyc(); smp();
        check("t3_w2_addr", vrf_waddr_o, 6);
        check("t3_w2_sel", vrf_wsel_o, 1);
        check("t3_rid1", result_id_o, 3);
        cyc(); smp();
        check("t3_rid2", result_id_o, 4);
        check("t3_we_off", vrf_we_o, 0);
        cyc(); smp();
        check("t3_idle", busy_o, 0);

        // Second tie: EXEC favoured by round-robin, LSU by age when in order
        cyc(); op(0, 8, 1, 6, 0, 0); smp();
        cyc(); op(1, 9, 1, 7, 0, 0); smp();
        cyc(); noop(); smp();
        cyc(); lsu_done_i = 1; exec_done_i = 1; smp();
        cyc(); lsu_done_i = 0; exec_done_i = 0; smp();
`ifdef VSCHED_INORDER_EN
        check("t3b_w1_addr", vrf_waddr_o, 8);
        check("t3b_w1_sel", vrf_wsel_o, 0);
        cyc(); smp();
        check("t3b_w2_addr", vrf_waddr_o, 9);
        check("t3b_rid1", result_id_o, 6);
        cyc(); smp();
        check("t3b_rid2", result_id_o, 7);
`else
        check("t3b_w1_addr", vrf_waddr_o, 9);
        check("t3b_w1_sel", vrf_wsel_o, 1);
        cyc(); smp();
        check("t3b_w2_addr", vrf_waddr_o, 8);
        check("t3b_rid1", result_id_o, 7);
        cyc(); smp();
        check("t3b_rid2", result_id_o, 6);
`endif
        cyc(); smp();
        check("t3b_idle", busy_o, 0);

        // Backpressure: LSU load id 8, EXEC non-writing op id 9
        cyc(); op(0, 10, 1, 8, 0, 0); smp();
        cyc(); op(1, 11, 0, 9, 0, 0); smp();
        cyc(); noop(); smp();
        cyc(); lsu_done_i = 1; exec_done_i = 1; smp();
        cyc(); lsu_done_i = 0; exec_done_i = 0; result_ready_i = 0; smp();
        check("t4_w1", vrf_we_o, 1);
        check("t4_w1_addr", vrf_waddr_o, 10);
        for (int i = 0; i < 5; i++) begin
            cyc(); smp();
            check("t4_hold_rv", result_valid_o, 1);
            check("t4_hold_rid", result_id_o, 8);
            check("t4_hold_we", vrf_we_o, 0);
            check("t4_hold_busy", busy_o, 1);
        end
        check("t4_sb", sb_o, 0);
        cyc(); result_ready_i = 1; smp();
        check("t4_st_we", vrf_we_o, 0);
        check("t4_st_addr", vrf_waddr_o, 11);
        check("t4_st_sel", vrf_wsel_o, 1);
        cyc(); smp();
        check("t4_rv2", result_valid_o, 1);
        check("t4_rid2", result_id_o, 9);
        cyc(); smp();
        check("t4_idle", busy_o, 0);

        // Completion order vs accept order: LSU id 1, EXEC id 2, EXEC done first
        cyc(); op(0, 12, 1, 1, 0, 0); smp();
        cyc(); op(1, 13, 1, 2, 0, 0); smp();
        cyc(); noop(); smp();
        cyc(); exec_done_i = 1; smp();
        cyc(); exec_done_i = 0; lsu_done_i = 1; smp();
`ifdef VSCHED_INORDER_EN
        check("t5_e_wait", vrf_we_o, 0);
        cyc(); lsu_done_i = 0; smp();
        check("t5_w1_addr", vrf_waddr_o, 12);
        check("t5_rv0", result_valid_o, 0);
        cyc(); smp();
        check("t5_w2_addr", vrf_waddr_o, 13);
        check("t5_rid1", result_id_o, 1);
        cyc(); smp();
        check("t5_rid2", result_id_o, 2);
`else
        check("t5_w1_addr", vrf_waddr_o, 13);
        check("t5_w1_we", vrf_we_o, 1);
        cyc(); lsu_done_i = 0; smp();
        check("t5_w2_addr", vrf_waddr_o, 12);
        check("t5_rid1", result_id_o, 2);
        cyc(); smp();
        check("t5_rid2", result_id_o, 1);
        cyc(); smp();
        check("t5_rv_drop", result_valid_o, 0);
`endif
        cyc(); smp();
        check("t5_idle", busy_o, 0);

        // Reset while EXEC is running with sb[7] set
        cyc(); op(1, 7, 1, 10, 0, 0); smp();
        cyc(); noop(); smp();
        cyc(); smp();
        check("t6_sb7", sb_o, 16'h0080);
        rst_ni = 1'b0;
        #1;
        check("t6_sb", sb_o, 0);
        check("t6_busy", busy_o, 0);
        check("t6_estart", exec_start_o, 0);
        check("t6_rv", result_valid_o, 0);
        check("t6_we", vrf_we_o, 0);
        cyc(); cyc();
        rst_ni = 1'b1;
        cyc(); op(1, 7, 1, 11, 1, 7); smp();
        check("t6_ready", op_ready_o, 1);
        cyc(); noop(); smp();
        check("t6_restart", exec_start_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
